// File: rtl/pc_gen.sv
// pc_gen: program-counter generator at the head of the fetch pipeline.
// Offers fetch addresses to IF over a valid/ready handshake, applies
// prioritised redirects (channel 0 highest), buffers a redirect that arrives
// while the pipeline is paused, and tags each offered PC with an epoch.
//
// Ports:
//   clk_in            clock, rising edge
//   rst_n_in          asynchronous active-low reset
//   rdy_in            global pipeline ready (0 = freeze, except redirect capture)
//   redir_valid_in    per-channel redirect request pulses
//   redir_addr_in     packed redirect targets, channel i at [i*ADDR_W +: ADDR_W]
//   pc_ready_in       IF accepts the offered PC
//   pc_out            offered fetch address
//   pc_valid_out      pc_out is valid
//   epoch_out         epoch tag of pc_out
//   redir_pending_out a buffered redirect awaits application
//
// Optional build macro PC_GEN_MISALIGN_CHK_EN adds misalign_out and
// misalign_addr_out; misaligned redirect targets are then dropped and reported.
module pc_gen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned NUM_REDIR = 2,
  parameter int unsigned EPOCH_W = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic [NUM_REDIR-1:0]          redir_valid_in,
  input  logic [NUM_REDIR*ADDR_W-1:0]   redir_addr_in,
  input  logic                          pc_ready_in,
  output logic [ADDR_W-1:0]             pc_out,
  output logic                          pc_valid_out,
  output logic [EPOCH_W-1:0]            epoch_out,
`ifdef PC_GEN_MISALIGN_CHK_EN
  output logic                          misalign_out,
  output logic [ADDR_W-1:0]             misalign_addr_out,
`endif
  output logic                          redir_pending_out
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
`ifdef PC_GEN_MISALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] MIS_MASK = ADDR_W'(STEP - 1);
`endif

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
`ifdef PC_GEN_MISALIGN_CHK_EN
  logic               mis_q, mis_d;
  logic [ADDR_W-1:0]  mis_addr_q, mis_addr_d;
`endif

  logic               live_any;
  logic [ADDR_W-1:0]  live_addr;
  logic               eff_valid;
  logic [ADDR_W-1:0]  eff_addr;
  logic               eff_bad;

  // Priority select: scanning downwards lets the lowest asserted index win.
  always_comb begin
    live_addr = '0;
    for (int i = int'(NUM_REDIR) - 1; i >= 0; i--) begin
      if (redir_valid_in[i]) live_addr = redir_addr_in[i*ADDR_W +: ADDR_W];
    end
  end

  assign live_any  = |redir_valid_in;
  assign eff_valid = live_any | pend_q;
  assign eff_addr  = live_any ? live_addr : pend_addr_q;

`ifdef PC_GEN_MISALIGN_CHK_EN
  assign eff_bad = eff_valid & (|(eff_addr & MIS_MASK));
`else
  assign eff_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= BOOT;
    else           state_q <= state_d;
  end

  // Next-state logic: leave BOOT on the first unpaused edge.
  always_comb begin
    state_d = state_q;
    if (state_q == BOOT && rdy_in) state_d = RUN;
  end

  // Next values for the registered outputs and the pending buffer.
  always_comb begin
    pc_d        = pc_q;
    valid_d     = valid_q;
    epoch_d     = epoch_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
`ifdef PC_GEN_MISALIGN_CHK_EN
    mis_d       = 1'b0;
    mis_addr_d  = mis_addr_q;
`endif
    if (!rdy_in) begin
      // Paused: only capture the newest live redirect.
      if (live_any) begin
        pend_d      = 1'b1;
        pend_addr_d = live_addr;
      end
    end else begin
      // Any pending entry is consumed (or superseded by a live one) now.
      pend_d = 1'b0;
      if (eff_bad) begin
`ifdef PC_GEN_MISALIGN_CHK_EN
        mis_d      = 1'b1;
        mis_addr_d = eff_addr;
`endif
        if (state_q == BOOT) begin
          valid_d = 1'b1;
          pc_d    = RESET_VEC;
        end
      end else if (state_q == BOOT) begin
        valid_d = 1'b1;
        pc_d    = eff_valid ? eff_addr : RESET_VEC;
        epoch_d = eff_valid ? EPOCH_W'(1) : '0;
      end else if (eff_valid) begin
        pc_d    = eff_addr;
        epoch_d = epoch_q + EPOCH_W'(1);
      end else if (pc_ready_in) begin
        pc_d = pc_q + STEP_V;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q        <= RESET_VEC;
      valid_q     <= 1'b0;
      epoch_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
`ifdef PC_GEN_MISALIGN_CHK_EN
      mis_q       <= 1'b0;
      mis_addr_q  <= '0;
`endif
    end else begin
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      epoch_q     <= epoch_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
`ifdef PC_GEN_MISALIGN_CHK_EN
      mis_q       <= mis_d;
      mis_addr_q  <= mis_addr_d;
`endif
    end
  end

  assign pc_out            = pc_q;
  assign pc_valid_out      = valid_q;
  assign epoch_out         = epoch_q;
  assign redir_pending_out = pend_q;
`ifdef PC_GEN_MISALIGN_CHK_EN
  assign misalign_out      = mis_q;
  assign misalign_addr_out = mis_addr_q;
`endif

endmodule
